// File: rtl/if_stage_if.sv
// Bus bundle for if_stage: fetch control inputs, instruction-memory handshake and IF/ID outputs.
// Defining IF_STAGE_PERF_EN adds the stall_cycles_o counter output.
interface if_stage_if;
    logic        start_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        imem_valid_i;
    logic [31:0] instr_o;
    logic [31:0] pc4_o;
    logic        valid_o;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] stall_cycles_o;

    modport master (
        input  start_i, stall_i, redirect_i, redirect_pc_i, imem_rdata_i, imem_valid_i,
        output imem_req_o, imem_addr_o, instr_o, pc4_o, valid_o, stall_cycles_o
    );
    modport slave (
        output start_i, stall_i, redirect_i, redirect_pc_i, imem_rdata_i, imem_valid_i,
        input  imem_req_o, imem_addr_o, instr_o, pc4_o, valid_o, stall_cycles_o
    );
`else
    modport master (
        input  start_i, stall_i, redirect_i, redirect_pc_i, imem_rdata_i, imem_valid_i,
        output imem_req_o, imem_addr_o, instr_o, pc4_o, valid_o
    );
    modport slave (
        output start_i, stall_i, redirect_i, redirect_pc_i, imem_rdata_i, imem_valid_i,
        input  imem_req_o, imem_addr_o, instr_o, pc4_o, valid_o
    );
`endif
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, 1-entry stall buffer, redirect squash.
// Optional stall-cycle counter enabled by defining IF_STAGE_PERF_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, SQUASH} state_t;

    state_t      state, state_nxt, resume;
    logic [31:0] pc, pc_nxt, pc_plus4, redirect_pc;
    logic [31:0] sq_addr, sq_addr_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic [31:0] instr_p1, instr_nxt;
    logic [31:0] pc4_p1, pc4_nxt;
    logic        vld_p1, vld_nxt;

    assign redirect_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
    assign pc_plus4    = pc + 32'd4;
    assign resume      = bus.start_i ? FETCH : IDLE;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        sq_addr_nxt    = sq_addr;
        hold_instr_nxt = hold_instr;
        instr_nxt      = instr_p1;
        pc4_nxt        = pc4_p1;
        vld_nxt        = vld_p1;
        case (state)
            IDLE: begin
                if (bus.redirect_i) begin
                    pc_nxt  = redirect_pc;
                    vld_nxt = 1'b0;
                end else if (!bus.stall_i) begin
                    vld_nxt = 1'b0;
                end
                if (bus.start_i) state_nxt = FETCH;
            end
            FETCH: begin
                if (bus.redirect_i) begin
                    pc_nxt  = redirect_pc;
                    vld_nxt = 1'b0;
                    if (bus.imem_valid_i) begin
                        state_nxt = resume;
                    end else begin
                        // Request cannot be cancelled: keep its address visible while it drains.
                        sq_addr_nxt = pc;
                        state_nxt   = SQUASH;
                    end
                end else if (bus.imem_valid_i) begin
                    if (bus.stall_i) begin
                        hold_instr_nxt = bus.imem_rdata_i;
                        state_nxt      = HOLD;
                    end else begin
                        instr_nxt = bus.imem_rdata_i;
                        pc4_nxt   = pc_plus4;
                        vld_nxt   = 1'b1;
                        pc_nxt    = pc_plus4;
                        state_nxt = resume;
                    end
                end else if (!bus.stall_i) begin
                    vld_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (bus.redirect_i) begin
                    pc_nxt    = redirect_pc;
                    vld_nxt   = 1'b0;
                    state_nxt = resume;
                end else if (!bus.stall_i) begin
                    instr_nxt = hold_instr;
                    pc4_nxt   = pc_plus4;
                    vld_nxt   = 1'b1;
                    pc_nxt    = pc_plus4;
                    state_nxt = resume;
                end
            end
            SQUASH: begin
                if (bus.redirect_i) pc_nxt = redirect_pc;
                if (bus.redirect_i || !bus.stall_i) vld_nxt = 1'b0;
                if (bus.imem_valid_i) state_nxt = resume;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // IF/ID boundary
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr_p1 <= 32'h0;
            pc4_p1   <= 32'h0;
            vld_p1   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            instr_p1 <= instr_nxt;
            pc4_p1   <= pc4_nxt;
            vld_p1   <= vld_nxt;
        end
    end

    // Buffer occupancy is implied by HOLD, so these capture registers need no reset.
    always_ff @(posedge clk_i) begin
        sq_addr    <= sq_addr_nxt;
        hold_instr <= hold_instr_nxt;
    end

    assign bus.imem_req_o  = (state == FETCH) || (state == SQUASH);
    assign bus.imem_addr_o = (state == SQUASH) ? sq_addr : pc;
    assign bus.instr_o     = instr_p1;
    assign bus.pc4_o       = pc4_p1;
    assign bus.valid_o     = vld_p1;

`ifdef IF_STAGE_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= 32'h0;
        end else if ((((state == FETCH) && !bus.imem_valid_i) || (state == SQUASH))
                     && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cycles_o = stall_cnt;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios plus randomized traffic against a transaction-level model.
module tb_if_stage;
    logic clk;
    logic rst;
    logic w_rst;
    int   checks   = 0;
    int   failures = 0;

    if_stage_if bus();
    if_stage_if w_bus();

    if_stage #(.RESET_PC(32'h0000_0000)) dut   (.clk_i(clk), .rst_i(rst),   .bus(bus));
    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (.clk_i(clk), .rst_i(w_rst), .bus(w_bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Zero-wait memory for the wrap-around instance: data equals address.
    always_comb begin
        w_bus.imem_valid_i = w_bus.imem_req_o;
        w_bus.imem_rdata_i = w_bus.imem_addr_o;
    end

    // Reference model: fetch running, squash pending, held response queue, IF/ID contents.
    bit          m_fetching, m_squash, m_valid;
    logic [31:0] m_pc, m_sq_addr, m_instr, m_pc4, m_perf;
    logic [31:0] m_hold[$];
    // Memory responder: data = address ^ mem_xor, latency fixed or random.
    int          mem_cnt, mem_lat, mem_fixed;
    logic [31:0] mem_xor;

    function automatic int next_lat();
        return (mem_fixed >= 0) ? mem_fixed : int'($urandom_range(0, 3));
    endfunction

    task automatic step(input bit st, input bit sl, input bit rd, input logic [31:0] rpc,
                        input bit rs, input bit sv);
        bit          req, mv;
        logic [31:0] a, md, rpa;
        req = m_fetching || m_squash;
        a   = m_squash ? m_sq_addr : m_pc;
        mv  = 1'b0;
        md  = 32'h0;
        if (req) begin
            mv = (mem_cnt >= mem_lat);
            md = a ^ mem_xor;
        end else if (sv) begin
            mv = 1'b1;
            md = $urandom;
        end
        rst               = rs;
        bus.start_i       = st;
        bus.stall_i       = sl;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.imem_valid_i  = mv;
        bus.imem_rdata_i  = md;
        rpa = rpc & 32'hFFFF_FFFC;
        if (rs) begin
            m_fetching = 1'b0; m_squash = 1'b0; m_hold.delete();
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_perf = 32'h0;
            mem_cnt = 0; mem_lat = next_lat();
        end else begin
            if (((m_fetching && !mv) || m_squash) && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
            if (req) begin
                if (mv) begin mem_cnt = 0; mem_lat = next_lat(); end
                else mem_cnt++;
            end
            if (m_squash) begin
                if (rd) m_pc = rpa;
                if (rd || !sl) m_valid = 1'b0;
                if (mv) begin m_squash = 1'b0; m_fetching = st; end
            end else if (m_hold.size() != 0) begin
                if (rd) begin
                    m_hold.delete(); m_pc = rpa; m_valid = 1'b0; m_fetching = st;
                end else if (!sl) begin
                    m_instr = m_hold.pop_front(); m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
                    m_valid = 1'b1; m_fetching = st;
                end
            end else if (m_fetching) begin
                if (rd) begin
                    m_valid = 1'b0;
                    if (mv) m_fetching = st;
                    else begin m_sq_addr = m_pc; m_squash = 1'b1; m_fetching = 1'b0; end
                    m_pc = rpa;
                end else if (mv) begin
                    if (sl) begin
                        m_hold.push_back(md); m_fetching = 1'b0;
                    end else begin
                        m_instr = md; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
                        m_valid = 1'b1; m_fetching = st;
                    end
                end else if (!sl) begin
                    m_valid = 1'b0;
                end
            end else begin
                if (rd) begin m_pc = rpa; m_valid = 1'b0; end
                else if (!sl) m_valid = 1'b0;
                if (st) m_fetching = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        mem_fixed = 0; mem_xor = 32'h0;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got %b want 0", bus.imem_req_o); end
        checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", bus.valid_o); end
        checks++; if (bus.instr_o !== 32'h0) begin failures++; $display("FAIL reset_instr got %h want 0", bus.instr_o); end
        checks++; if (bus.pc4_o !== 32'h0) begin failures++; $display("FAIL reset_pc4 got %h want 0", bus.pc4_o); end
`ifdef IF_STAGE_PERF_EN
        checks++; if (bus.stall_cycles_o !== 32'h0) begin failures++; $display("FAIL reset_perf got %0d want 0", bus.stall_cycles_o); end
`endif
    endtask

    task automatic test_zero_wait();
        mem_fixed = 0; mem_xor = 32'h0;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL zw_first_req got req=%b addr=%h want req=1 addr=0", bus.imem_req_o, bus.imem_addr_o); end
        checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL zw_cycle1_valid got %b want 0", bus.valid_o); end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL zw_valid[%0d] got %b want 1", k, bus.valid_o); end
            checks++; if (bus.instr_o !== 32'(k * 4)) begin failures++; $display("FAIL zw_instr[%0d] got %h want %h", k, bus.instr_o, 32'(k * 4)); end
            checks++; if (bus.pc4_o !== 32'(k * 4 + 4)) begin failures++; $display("FAIL zw_pc4[%0d] got %h want %h", k, bus.pc4_o, 32'(k * 4 + 4)); end
        end
    endtask

    task automatic test_latency();
        mem_fixed = 2; mem_xor = 32'hA000_0000;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 3; c++) begin
                checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'(f * 4)) begin
                    failures++; $display("FAIL lat_addr[%0d.%0d] got req=%b addr=%h want req=1 addr=%h", f, c, bus.imem_req_o, bus.imem_addr_o, 32'(f * 4)); end
                if (c > 0) begin
                    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL lat_bubble[%0d.%0d] got %b want 0", f, c, bus.valid_o); end
                end
                step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            end
            checks++; if (bus.valid_o !== 1'b1 || bus.instr_o !== (32'(f * 4) ^ 32'hA000_0000)) begin
                failures++; $display("FAIL lat_instr[%0d] got v=%b %h want v=1 %h", f, bus.valid_o, bus.instr_o, 32'(f * 4) ^ 32'hA000_0000); end
`ifdef IF_STAGE_PERF_EN
            checks++; if (bus.stall_cycles_o !== 32'(2 * (f + 1))) begin
                failures++; $display("FAIL lat_perf[%0d] got %0d want %0d", f, bus.stall_cycles_o, 2 * (f + 1)); end
`endif
        end
    endtask

    task automatic test_stall_hold();
        mem_fixed = 0; mem_xor = 32'h0000_5000;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int s = 0; s < 2; s++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            checks++; if (bus.imem_req_o !== 1'b0) begin failures++; $display("FAIL hold_req[%0d] got %b want 0", s, bus.imem_req_o); end
            checks++; if (bus.valid_o !== 1'b1 || bus.instr_o !== 32'h0000_5000 || bus.pc4_o !== 32'h4) begin
                failures++; $display("FAIL hold_frozen[%0d] got v=%b %h %h want v=1 00005000 00000004", s, bus.valid_o, bus.instr_o, bus.pc4_o); end
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.valid_o !== 1'b1 || bus.instr_o !== 32'h0000_5004 || bus.pc4_o !== 32'h8) begin
            failures++; $display("FAIL hold_release got v=%b %h %h want v=1 00005004 00000008", bus.valid_o, bus.instr_o, bus.pc4_o); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h8) begin
            failures++; $display("FAIL hold_resume got req=%b addr=%h want req=1 addr=8", bus.imem_req_o, bus.imem_addr_o); end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.instr_o !== 32'h0000_5008 || bus.pc4_o !== 32'hC) begin
            failures++; $display("FAIL hold_next got %h %h want 00005008 0000000c", bus.instr_o, bus.pc4_o); end
    endtask

    task automatic test_redirect();
        mem_fixed = 2; mem_xor = 32'h0BAD_0000;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0203, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b0);
        checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL redir_valid got %b want 0", bus.valid_o); end
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL redir_old_addr got req=%b addr=%h want req=1 addr=0", bus.imem_req_o, bus.imem_addr_o); end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0000_0100) begin
                failures++; $display("FAIL redir_new_addr[%0d] got req=%b addr=%h want req=1 addr=00000100", c, bus.imem_req_o, bus.imem_addr_o); end
            checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL redir_bubble[%0d] got %b want 0", c, bus.valid_o); end
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        checks++; if (bus.valid_o !== 1'b1 || bus.instr_o !== 32'h0BAD_0100 || bus.pc4_o !== 32'h0000_0104) begin
            failures++; $display("FAIL redir_target got v=%b %h %h want v=1 0bad0100 00000104", bus.valid_o, bus.instr_o, bus.pc4_o); end
    endtask

    task automatic test_reset_mid();
        mem_fixed = 0; mem_xor = 32'h7700_0000;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        mem_fixed = 2;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.valid_o !== 1'b1 || bus.instr_o !== 32'h7700_0000) begin
            failures++; $display("FAIL rstmid_pre got v=%b %h want v=1 77000000", bus.valid_o, bus.instr_o); end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int s = 0; s < 3; s++) begin
            checks++; if (bus.imem_req_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.instr_o !== 32'h0 || bus.pc4_o !== 32'h0) begin
                failures++; $display("FAIL rstmid_idle[%0d] got req=%b v=%b %h %h want all 0", s, bus.imem_req_o, bus.valid_o, bus.instr_o, bus.pc4_o); end
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin
            failures++; $display("FAIL rstmid_restart got req=%b addr=%h want req=1 addr=0", bus.imem_req_o, bus.imem_addr_o); end
    endtask

    task automatic test_wrap();
        w_rst = 1'b1; w_bus.start_i = 1'b0;
        @(posedge clk); @(negedge clk);
        w_rst = 1'b0; w_bus.start_i = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (w_bus.imem_req_o !== 1'b1 || w_bus.imem_addr_o !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_first got req=%b addr=%h want req=1 addr=fffffffc", w_bus.imem_req_o, w_bus.imem_addr_o); end
        @(posedge clk); @(negedge clk);
        checks++; if (w_bus.valid_o !== 1'b1 || w_bus.instr_o !== 32'hFFFF_FFFC || w_bus.pc4_o !== 32'h0) begin
            failures++; $display("FAIL wrap_pc4 got v=%b %h %h want v=1 fffffffc 00000000", w_bus.valid_o, w_bus.instr_o, w_bus.pc4_o); end
        checks++; if (w_bus.imem_addr_o !== 32'h0) begin failures++; $display("FAIL wrap_second_addr got %h want 0", w_bus.imem_addr_o); end
        @(posedge clk); @(negedge clk);
        checks++; if (w_bus.instr_o !== 32'h0 || w_bus.pc4_o !== 32'h4) begin
            failures++; $display("FAIL wrap_next got %h %h want 00000000 00000004", w_bus.instr_o, w_bus.pc4_o); end
    endtask

    task automatic test_random();
        bit exp_req;
        mem_fixed = -1; mem_xor = $urandom;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                 $urandom, $urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0);
            exp_req = m_fetching || m_squash;
            checks++; if (bus.imem_req_o !== exp_req) begin failures++; $display("FAIL rnd_req[%0d] got %b want %b", n, bus.imem_req_o, exp_req); end
            if (exp_req) begin
                checks++; if (bus.imem_addr_o !== (m_squash ? m_sq_addr : m_pc)) begin
                    failures++; $display("FAIL rnd_addr[%0d] got %h want %h", n, bus.imem_addr_o, m_squash ? m_sq_addr : m_pc); end
            end
            checks++; if (bus.valid_o !== m_valid) begin failures++; $display("FAIL rnd_valid[%0d] got %b want %b", n, bus.valid_o, m_valid); end
            checks++; if (bus.instr_o !== m_instr || bus.pc4_o !== m_pc4) begin
                failures++; $display("FAIL rnd_data[%0d] got %h %h want %h %h", n, bus.instr_o, bus.pc4_o, m_instr, m_pc4); end
`ifdef IF_STAGE_PERF_EN
            checks++; if (bus.stall_cycles_o !== m_perf) begin
                failures++; $display("FAIL rnd_perf[%0d] got %0d want %0d", n, bus.stall_cycles_o, m_perf); end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; w_rst = 1'b1;
        bus.start_i = 1'b0; bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'h0;
        bus.imem_valid_i = 1'b0; bus.imem_rdata_i = 32'h0;
        w_bus.start_i = 1'b0; w_bus.stall_i = 1'b0; w_bus.redirect_i = 1'b0; w_bus.redirect_pc_i = 32'h0;
        mem_fixed = 0; mem_xor = 32'h0; mem_cnt = 0; mem_lat = 0;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_redirect();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  fetch enable; fetching begins from IDLE when high.
REQ-005 stall_i  input  1  hazard hold from downstream; IF/ID outputs frozen while high.
REQ-006 redirect_i  input  1  taken branch/jump; flushes fetch and IF/ID output.
REQ-007 redirect_pc_i  input  32  redirect target; bits [1:0] forced to 0.
REQ-008 imem_req_o  output  1  instruction memory request.
REQ-009 imem_addr_o  output  32  request address; stable while imem_req_o high until imem_valid_i.
REQ-010 imem_rdata_i  input  32  instruction word; valid when imem_valid_i high.
REQ-011 imem_valid_i  input  1  response strobe; may assert in the same cycle as the request (zero-wait memory).
REQ-012 instr_o  output  32  registered instruction to IF/ID consumer.
REQ-013 pc4_o  output  32  registered address of instr_o plus 4.
REQ-014 valid_o  output  1  instr_o/pc4_o hold a live instruction; 0 = bubble.

Function
REQ-015 States: IDLE, FETCH, HOLD, SQUASH; one request outstanding at most; no request cancel.
REQ-016 IDLE: imem_req_o=0; start_i=1 -> FETCH next cycle.
REQ-017 FETCH: imem_req_o=1, imem_addr_o=pc; held until imem_valid_i=1.
REQ-018 FETCH, imem_valid_i=1, redirect_i=0, stall_i=0: instr_o<=rdata, pc4_o<=pc+4, valid_o<=1, pc<=pc+4; stay FETCH (1 instr/cycle with zero-wait memory).
REQ-019 FETCH, imem_valid_i=1, redirect_i=0, stall_i=1: response captured in 1-entry buffer, outputs unchanged, -> HOLD.
REQ-020 FETCH, imem_valid_i=0, stall_i=0, redirect_i=0: valid_o<=0 (bubble), other outputs hold.
REQ-021 HOLD: imem_req_o=0; stall_i=0 -> buffer to outputs, valid_o<=1, pc<=pc+4, -> FETCH.
REQ-022 redirect_i=1 has priority over stall_i and imem_valid_i in every state: valid_o<=0 next cycle, pc<=redirect_pc_i, buffer dropped.
REQ-023 redirect_i=1 in FETCH with imem_valid_i=0: -> SQUASH; old address held on imem_addr_o until imem_valid_i, response discarded, then -> FETCH at redirect pc.
REQ-024 redirect_i=1 in FETCH with imem_valid_i=1, or in HOLD: response/buffer discarded, -> FETCH next cycle at redirect pc.
REQ-025 Second redirect in SQUASH: target overwritten, latest wins.
REQ-026 start_i=0 outside IDLE: outstanding request completes per REQ-018..024, then -> IDLE; HOLD drains first.
REQ-027 pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-028 stall_i=1 with no redirect: instr_o, pc4_o, valid_o unchanged.

Reset
REQ-029 rst_i=1 at a clock edge: state<=IDLE, pc<=RESET_PC, buffer empty, valid_o=0, instr_o=0, pc4_o=0, imem_req_o=0.
REQ-030 Reset mid-transaction abandons the outstanding request; any imem_valid_i arriving after reset in IDLE is ignored.

Configuration
REQ-031 Macro IF_STAGE_PERF_EN defined: extra output stall_cycles_o (32) counts cycles in FETCH with imem_req_o=1 and imem_valid_i=0 plus all SQUASH cycles; saturates at 32'hFFFF_FFFF; cleared by reset.
REQ-032 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-033 Reset, start_i=1, zero-wait memory returning addr as data -> valid_o from cycle 2, instr_o=0,4,8..., pc4_o=4,8,12...
REQ-034 Memory 3-cycle latency -> imem_addr_o stable 3 cycles, valid_o=0 in 2 bubble cycles, then one instr; stall_cycles_o=2 per fetch with IF_STAGE_PERF_EN.
REQ-035 stall_i=1 for 2 cycles while response arrives -> outputs frozen, HOLD, imem_req_o=0; release -> buffered instr delivered, fetch resumes at pc+4.
REQ-036 redirect_i=1, redirect_pc_i=32'h0000_0103 during pending 3-cycle fetch -> valid_o=0, old response dropped, next imem_addr_o=32'h0000_0100.
REQ-037 RESET_PC=32'hFFFF_FFFC, zero-wait -> second fetch address 32'h0000_0000; rst_i mid-fetch -> outputs zero, state IDLE, late imem_valid_i ignored.
